uart_tx_scheduler: RTL

Round-robin scheduler that shares one UART transmitter (BaudGen + frame serializer) between NUM_REQ byte requesters. Each requester supplies its own byte and baud selection. The scheduler captures a granted request and drives the shared baud_rate select, holding it stable for the whole frame. After any rate change it waits a settle period before starting the frame. It sits between the host-side requesters and the UART-Tx top.

---
 rtl/uart_tx_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte requesters.
// Optional watchdog is compiled in when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SETTLE_CYCLES = 16
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]          req_baud,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [1:0]                    baud_rate,
    output logic                          tx_send,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic                          sched_busy,
    output logic                          timeout_err
);
    localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [1:0]  BAUD_RST = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        SETTLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_ptr;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    r_grant;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [1:0]            r_baud;
    logic [1:0]            r_next_baud;
    logic [SCW-1:0]        r_settle;
    logic                  r_tx_send;

    logic                  w_any;
    logic [PW-1:0]         w_win;
    logic [PW-1:0]         w_ptr_next;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [1:0]            w_win_baud;
    logic                  w_frame_end;
    logic                  w_timeout;

    // Search order starts at r_ptr; the first requester found with req=1 wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_any && req[i] && (i == (32'(r_ptr) + k) % NUM_REQ)) begin
                    w_any = 1'b1;
                    w_win = PW'(i);
                end
            end
        end
    end

    always_comb begin
        w_win_oh   = '0;
        w_win_data = '0;
        w_win_baud = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_oh[i] = 1'b1;
                w_win_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_win_baud  = req_baud[i*2 +: 2];
            end
        end
    end

    assign w_ptr_next  = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_frame_end = tx_done && (r_state == WAIT_BUSY || r_state == WAIT_DONE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    // A genuine end of frame in the same cycle takes priority over the watchdog.
    assign w_timeout = (r_state == WAIT_BUSY || r_state == WAIT_DONE) && !w_frame_end
                       && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_any) w_next = CFG;
            CFG:       w_next = (r_next_baud == r_baud) ? SEND : SETTLE;
            SETTLE:    if (r_settle == '0) w_next = SEND;
            SEND:      w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_done) begin
                    w_next = IDLE;
                end else if (tx_busy) begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: if (tx_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = IDLE;
        end
    end

    // tx_send is registered out of SEND, giving the two-cycle ack-to-send latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_ack       <= '0;
            r_grant     <= '0;
            r_tx_data   <= '0;
            r_baud      <= BAUD_RST;
            r_next_baud <= BAUD_RST;
            r_settle    <= '0;
            r_tx_send   <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_tx_send <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ack       <= w_win_oh;
                        r_grant     <= w_win_oh;
                        r_tx_data   <= w_win_data;
                        r_next_baud <= w_win_baud;
                        r_ptr       <= w_ptr_next;
                    end
                end
                CFG: begin
                    if (r_next_baud != r_baud) begin
                        r_baud   <= r_next_baud;
                        r_settle <= SCW'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                SEND:    r_tx_send <= 1'b1;
                default: ;
            endcase
            if (w_frame_end || w_timeout) begin
                r_grant <= '0;
            end
        end
    end

    assign ack        = r_ack;
    assign grant      = r_grant;
    assign tx_data    = r_tx_data;
    assign baud_rate  = r_baud;
    assign tx_send    = r_tx_send;
    assign sched_busy = (r_state != IDLE);

endmodule
